// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared control-flow types, branch condition codes and memctl layout
package riscv_pkg;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cf_type_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // memctl = {memread, memwrite, size[1:0]}
    localparam int MEMCTL_W       = 4;
    localparam int MEMCTL_READ    = 3;
    localparam int MEMCTL_WRITE   = 2;
    localparam int MEMCTL_SIZE_HI = 1;
    localparam int MEMCTL_SIZE_LO = 0;

    function automatic logic is_link(input cf_type_e cf);
        return (cf == CF_JAL) || (cf == CF_JALR);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - combinational taken decision and control-flow target
module branch_resolve
    import riscv_pkg::*;
(
    input  cf_type_e    cf_type,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        lstbit,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] aluout,
    output logic        taken,
    output logic [31:0] target,
    output logic        misaligned
);

    always_comb begin
        taken = 1'b0;
        case (cf_type)
            CF_BRANCH: begin
                // ALU already ran SUB/SLT/SLTU, so only zero and bit 0 matter
                case (funct3)
                    F3_BEQ:            taken = zero;
                    F3_BNE:            taken = !zero;
                    F3_BLT,  F3_BLTU:  taken = lstbit;
                    F3_BGE,  F3_BGEU:  taken = !lstbit;
                    default:           taken = 1'b0;
                endcase
            end
            CF_JAL, CF_JALR: taken = 1'b1;
            default:         taken = 1'b0;
        endcase
    end

    assign target     = (cf_type == CF_JALR) ? {aluout[31:1], 1'b0} : pc + imm;
    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with control-flow resolution and squash
module ex_mem_stage
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [31:0]         ex_pc,
    input  logic [31:0]         ex_aluout,
    input  logic                ex_zero,
    input  logic                ex_lstbit,
    input  logic [1:0]          ex_cf_type,
    input  logic [2:0]          ex_funct3,
    input  logic [31:0]         ex_imm,
    input  logic [31:0]         ex_rs2data,
    input  logic [4:0]          ex_rd,
    input  logic                ex_regwrite,
    input  logic [MEMCTL_W-1:0] ex_memctl,
    input  logic                mem_stall,
    output logic                mem_valid,
    output logic [31:0]         mem_result,
    output logic [31:0]         mem_wdata,
    output logic [4:0]          mem_rd,
    output logic                mem_regwrite,
    output logic [MEMCTL_W-1:0] mem_memctl,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                misalign_exc,
    output logic [CNT_W-1:0]    taken_cnt
);

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } state_e;

    state_e      state;
    cf_type_e    cf;
    logic        taken;
    logic        misaligned;
    logic [31:0] target;
    logic        bubble;
    logic        act;
    logic        keep_ctl;

    assign cf = cf_type_e'(ex_cf_type);

    branch_resolve u_branch_resolve (
        .cf_type    (cf),
        .funct3     (ex_funct3),
        .zero       (ex_zero),
        .lstbit     (ex_lstbit),
        .pc         (ex_pc),
        .imm        (ex_imm),
        .aluout     (ex_aluout),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned)
    );

    // An instruction entering in SQUASH sits in the shadow of a redirect and must die
    assign bubble   = (state == ST_SQUASH) || !ex_valid;
    assign act      = !bubble && taken;
    assign keep_ctl = !bubble && !(act && misaligned);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_wdata      <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memctl     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_exc   <= 1'b0;
            taken_cnt      <= '0;
        end else begin
            redirect_valid <= 1'b0;
            misalign_exc   <= 1'b0;
            if (!mem_stall) begin
                mem_valid    <= ex_valid && (state == ST_RUN);
                mem_result   <= is_link(cf) ? ex_pc + 32'd4 : ex_aluout;
                mem_wdata    <= ex_rs2data;
                mem_rd       <= ex_rd;
                mem_regwrite <= ex_regwrite && keep_ctl;
                mem_memctl   <= keep_ctl ? ex_memctl : '0;
                if (act && !misaligned) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                    taken_cnt      <= taken_cnt + 1'b1;
                end
                if (act && misaligned) begin
                    misalign_exc <= 1'b1;
                end
                state <= act ? ST_SQUASH : ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized and directed bench for ex_mem_stage
module tb_ex_mem_stage;
    import riscv_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid = 1'b0;
    logic [31:0]      ex_pc = '0;
    logic [31:0]      ex_aluout = '0;
    logic             ex_zero = 1'b0;
    logic             ex_lstbit = 1'b0;
    logic [1:0]       ex_cf_type = '0;
    logic [2:0]       ex_funct3 = '0;
    logic [31:0]      ex_imm = '0;
    logic [31:0]      ex_rs2data = '0;
    logic [4:0]       ex_rd = '0;
    logic             ex_regwrite = 1'b0;
    logic [3:0]       ex_memctl = '0;
    logic             mem_stall = 1'b0;
    logic             mem_valid;
    logic [31:0]      mem_result;
    logic [31:0]      mem_wdata;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic [3:0]       mem_memctl;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             misalign_exc;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_aluout      (ex_aluout),
        .ex_zero        (ex_zero),
        .ex_lstbit      (ex_lstbit),
        .ex_cf_type     (ex_cf_type),
        .ex_funct3      (ex_funct3),
        .ex_imm         (ex_imm),
        .ex_rs2data     (ex_rs2data),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memctl      (ex_memctl),
        .mem_stall      (mem_stall),
        .mem_valid      (mem_valid),
        .mem_result     (mem_result),
        .mem_wdata      (mem_wdata),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_memctl     (mem_memctl),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_exc   (misalign_exc),
        .taken_cnt      (taken_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each rule says, evaluated on the sampled EX inputs
    function automatic logic ref_taken(input logic [1:0] cf, input logic [2:0] f3,
                                       input logic z, input logic l);
        if (cf == 2'd2 || cf == 2'd3) return 1'b1;
        if (cf != 2'd1) return 1'b0;
        case (f3)
            3'd0:       return z;
            3'd1:       return !z;
            3'd4, 3'd6: return l;
            3'd5, 3'd7: return !l;
            default:    return 1'b0;
        endcase
    endfunction

    wire        m_taken = ref_taken(ex_cf_type, ex_funct3, ex_zero, ex_lstbit);
    wire [31:0] m_tgt   = (ex_cf_type == 2'd3) ? (ex_aluout & 32'hFFFF_FFFE) : ex_pc + ex_imm;
    wire        m_mis   = (m_tgt % 4) != 0;

    logic             e_valid, e_regwrite, e_redir, e_mis, in_shadow;
    logic [31:0]      e_result, e_wdata, e_rpc;
    logic [4:0]       e_rd;
    logic [3:0]       e_memctl;
    logic [CNT_W-1:0] e_cnt;

    wire m_live = ex_valid && !in_shadow;
    wire m_act  = m_live && m_taken;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 0; e_regwrite <= 0; e_redir <= 0; e_mis <= 0; in_shadow <= 0;
            e_result <= 0; e_wdata <= 0; e_rpc <= 0; e_rd <= 0; e_memctl <= 0; e_cnt <= 0;
        end else begin
            e_redir <= 0;
            e_mis   <= 0;
            if (!mem_stall) begin
                e_valid    <= m_live;
                e_result   <= (ex_cf_type >= 2'd2) ? ex_pc + 4 : ex_aluout;
                e_wdata    <= ex_rs2data;
                e_rd       <= ex_rd;
                e_regwrite <= (m_live && !(m_act && m_mis)) ? ex_regwrite : 1'b0;
                e_memctl   <= (m_live && !(m_act && m_mis)) ? ex_memctl : 4'd0;
                if (m_act && !m_mis) begin
                    e_redir <= 1;
                    e_rpc   <= m_tgt;
                    e_cnt   <= (e_cnt + 1) % (1 << CNT_W);
                end
                if (m_act && m_mis) e_mis <= 1;
                in_shadow <= m_act;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid", mem_valid, e_valid);
            chk("cmp_result", mem_result, e_result);
            chk("cmp_wdata", mem_wdata, e_wdata);
            chk("cmp_rd", mem_rd, e_rd);
            chk("cmp_regwrite", mem_regwrite, e_regwrite);
            chk("cmp_memctl", mem_memctl, e_memctl);
            chk("cmp_redirect", redirect_valid, e_redir);
            if (e_redir) chk("cmp_redirect_pc", redirect_pc, e_rpc);
            chk("cmp_misalign", misalign_exc, e_mis);
            chk("cmp_cnt", taken_cnt, e_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic v, input logic [1:0] cf, input logic [2:0] f3,
                       input logic z, input logic l, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] alu, input logic rw);
        ex_valid = v; ex_cf_type = cf; ex_funct3 = f3; ex_zero = z; ex_lstbit = l;
        ex_pc = pc; ex_imm = imm; ex_aluout = alu; ex_regwrite = rw;
        ex_rd = 5'd7; ex_rs2data = 32'hA5A5_0000 ^ pc; ex_memctl = 4'b1010; mem_stall = 1'b0;
    endtask

    task automatic idle();
        put(1'b0, CF_NONE, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        ex_memctl = 4'd0;
    endtask

    initial begin
        idle();
        repeat (3) @(negedge clk);
        chk("reset_valid", mem_valid, 0);
        chk("reset_redirect", redirect_valid, 0);
        chk("reset_cnt", taken_cnt, 0);
        chk("reset_result", mem_result, 0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        // BEQ taken, following instruction squashed
        put(1, CF_BRANCH, F3_BEQ, 1, 0, 32'h100, 32'h20, 32'h0, 0); tick();
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_cnt", taken_cnt, 1);
        put(1, CF_NONE, 0, 0, 0, 32'h104, 0, 32'h55, 1); tick();
        chk("beq_squash_valid", mem_valid, 0);
        chk("beq_squash_rw", mem_regwrite, 0);
        chk("beq_pulse_end", redirect_valid, 0);

        // BLT not taken
        put(1, CF_BRANCH, F3_BLT, 0, 0, 32'h200, 32'h40, 32'h0, 0); tick();
        chk("blt_redirect", redirect_valid, 0);
        put(1, CF_NONE, 0, 0, 0, 32'h204, 0, 32'h77, 1); tick();
        chk("blt_next_valid", mem_valid, 1);
        chk("blt_next_result", mem_result, 32'h77);

        // JALR to misaligned target
        put(1, CF_JALR, 0, 0, 1, 32'h300, 0, 32'h2003, 1); tick();
        chk("jalr_misalign", misalign_exc, 1);
        chk("jalr_redirect", redirect_valid, 0);
        chk("jalr_rw", mem_regwrite, 0);
        chk("jalr_memctl", mem_memctl, 0);
        chk("jalr_cnt", taken_cnt, 1);
        put(1, CF_NONE, 0, 0, 0, 32'h304, 0, 32'h1, 1); tick();
        chk("jalr_squash", mem_valid, 0);

        // JAL followed by a 3-cycle stall
        put(1, CF_JAL, 0, 0, 0, 32'h40, 32'h100, 32'h0, 1); tick();
        chk("jal_redirect", redirect_valid, 1);
        chk("jal_pc", redirect_pc, 32'h140);
        chk("jal_result", mem_result, 32'h44);
        put(1, CF_NONE, 0, 0, 0, 32'h44, 0, 32'h99, 1);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("jal_stall_pulse", redirect_valid, 0);
            chk("jal_stall_hold", mem_result, 32'h44);
        end
        mem_stall = 1'b0; tick();
        chk("jal_squash_after_stall", mem_valid, 0);
        chk("jal_cnt", taken_cnt, 2);
        put(1, CF_NONE, 0, 0, 0, 32'h48, 0, 32'hAB, 1); tick();
        chk("jal_resume", mem_result, 32'hAB);

        // Counter wrap at 4 bits
        for (int i = 0; i < 13; i++) begin
            put(1, CF_JAL, 0, 0, 0, 32'h1000 + i * 16, 32'h8, 32'h0, 1); tick();
            idle(); tick();
        end
        chk("cnt_15", taken_cnt, 15);
        put(1, CF_JAL, 0, 0, 0, 32'h2000, 32'h8, 32'h0, 1); tick();
        chk("cnt_wrap", taken_cnt, 0);
        chk("cnt_wrap_pulse", redirect_valid, 1);
        idle(); tick();

        // Reset while in SQUASH with a redirect pulse live
        put(1, CF_BRANCH, F3_BNE, 0, 0, 32'h500, 32'h10, 32'h0, 0); tick();
        chk("sq_redirect", redirect_valid, 1);
        idle();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_valid", mem_valid, 0);
        chk("rst_result", mem_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        put(1, CF_NONE, 0, 0, 0, 32'h600, 0, 32'h1234, 1); tick();
        chk("post_rst_valid", mem_valid, 1);
        chk("post_rst_rw", mem_regwrite, 1);
        chk("post_rst_result", mem_result, 32'h1234);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_cf_type  = 2'($urandom_range(0, 3));
            ex_funct3   = 3'($urandom_range(0, 7));
            ex_zero     = 1'($urandom_range(0, 1));
            ex_lstbit   = 1'($urandom_range(0, 1));
            ex_pc       = $urandom & 32'hFFFF_FFFC;
            ex_imm      = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ex_aluout   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ex_rs2data  = $urandom;
            ex_rd       = 5'($urandom_range(0, 31));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_memctl   = 4'($urandom_range(0, 15));
            mem_stall   = ($urandom_range(0, 3) == 0);
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the taken-control-flow counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_valid  input  1  EX slot holds a real instruction.
REQ-005 SHALL have port ex_pc  input  32  PC of EX instruction.
REQ-006 SHALL have port ex_aluout  input  32  ALU result.
REQ-007 SHALL have port ex_zero  input  1  ALU result equals zero.
REQ-008 SHALL have port ex_lstbit  input  1  ALU result bit 0.
REQ-009 SHALL have port ex_cf_type  input  2  control-flow type: NONE, BRANCH, JAL, JALR.
REQ-010 SHALL have port ex_funct3  input  3  branch condition code.
REQ-011 SHALL have port ex_imm  input  32  sign-extended immediate.
REQ-012 SHALL have port ex_rs2data  input  32  store data.
REQ-013 SHALL have port ex_rd  input  5  destination register.
REQ-014 SHALL have port ex_regwrite  input  1  writes rd.
REQ-015 SHALL have port ex_memctl  input  4  {memread, memwrite, size[1:0]}.
REQ-016 SHALL have port mem_stall  input  1  hold EX/MEM contents.
REQ-017 SHALL have port mem_valid  output  1  registered slot valid.
REQ-018 SHALL have port mem_result  output  32  registered ALU result or link address.
REQ-019 SHALL have ports mem_wdata (32), mem_rd (5), mem_regwrite (1), mem_memctl (4), all outputs, registered copies of the ex_ fields.
REQ-020 SHALL have port redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-021 SHALL have port redirect_pc  output  32  redirect target.
REQ-022 SHALL have port misalign_exc  output  1  one-cycle misaligned-target pulse.
REQ-023 SHALL have port taken_cnt  output  CNT_W  count of taken control-flow instructions.

Function
REQ-024 SHALL compute taken for BRANCH: BEQ=zero, BNE=!zero, BLT/BLTU=lstbit, BGE/BGEU=!lstbit (ALU performed SUB/SLT/SLTU); other funct3 values are not taken.
REQ-025 SHALL treat JAL and JALR as always taken.
REQ-026 SHALL compute targets as follows: BRANCH and JAL -> ex_pc+ex_imm (mod 2^32); JALR -> ex_aluout with bit 0 cleared.
REQ-027 SHALL capture ex_* into the mem_* registers on a clock edge with mem_stall=0; mem_result = ex_pc+4 for JAL/JALR, else ex_aluout.
REQ-028 SHALL hold every mem_* register unchanged while mem_stall=1.
REQ-029 SHALL, when a valid taken instruction is captured, assert redirect_valid with redirect_pc=target in the cycle after the capture, for exactly one cycle, even if mem_stall rises in that cycle.
REQ-030 SHALL, if target[1:0]!=0, pulse misalign_exc instead of redirect_valid, and capture the slot with regwrite=0 and memctl=0.
REQ-031 SHALL run FSM RUN/SQUASH: RUN->SQUASH on capture of taken or misaligned; in SQUASH, the next non-stalled capture is forced to bubble (valid=0, regwrite=0, memctl=0), then ->RUN; SQUASH holds under mem_stall.
REQ-032 SHALL NOT redirect, count, or raise misalign_exc for an instruction captured as a bubble in SQUASH; a taken branch squashed this way has no effect.
REQ-033 SHALL increment taken_cnt once per redirect_valid pulse, wrapping from 2^CNT_W-1 to 0.
REQ-034 SHALL treat ex_valid=0 as a bubble: all control fields captured as 0, no redirect, no count.

Reset
REQ-035 SHALL, on rst_n=0 (asynchronous, any time, including mid-redirect or in SQUASH), clear all mem_* outputs, redirect_valid, redirect_pc, misalign_exc and taken_cnt to 0, and set the FSM to RUN.
REQ-036 SHALL produce its first capture on the first rising clk edge after rst_n deasserts.

Structure
REQ-037 SHALL take cf_type_e, BEQ/BNE/BLT/BGE/BLTU/BGEU funct3 constants and memctl field positions from the shared package riscv_pkg.
REQ-038 SHALL implement the taken decision and target computation in one combinational sub-module, branch_resolve.

Verification
REQ-039 SHALL test BEQ with zero=1, pc=0x100, imm=0x20 -> redirect_valid one cycle, redirect_pc=0x120, taken_cnt=1, following instruction squashed.
REQ-040 SHALL test BLT with lstbit=0 -> no redirect; next instruction captured with mem_valid=1.
REQ-041 SHALL test JALR with aluout=0x2003 -> redirect_pc=0x2002 misaligned -> misalign_exc=1, no redirect, mem_regwrite=0.
REQ-042 SHALL test JAL at pc=0x40 with mem_stall=1 for 3 cycles after capture -> single redirect pulse, mem_result=0x44 held, squash applied on the first unstalled capture.
REQ-043 SHALL test taken_cnt preset near wrap (CNT_W=4, 15 taken) plus one more taken -> taken_cnt=0.
REQ-044 SHALL test rst_n asserted while in SQUASH -> all outputs 0 immediately; the first instruction after release is captured normally.
